apb_master_ctrl: RTL and testbench
==================================

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 SHALL provide parameter: WAIT_LIMIT, 16, maximum ACCESS cycles without pready_i before abort (range 2..255).
REQ-002 SHALL provide port: pclk  in  1  clock, all logic rising-edge.
REQ-003 SHALL provide port: preset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: cmd_valid  in  1  command request.
REQ-005 SHALL provide port: cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clock edge.
REQ-006 SHALL provide port: cmd_addr  in  32  transfer address.
REQ-007 SHALL provide port: cmd_write  in  1  1 = write, 0 = read.
REQ-008 SHALL provide port: cmd_wdata  in  8  write data.
REQ-009 SHALL provide port: rsp_valid  out  1  one-cycle completion pulse.
REQ-010 SHALL provide port: rsp_rdata  out  8  read data, valid with rsp_valid.
REQ-011 SHALL provide port: rsp_err  out  1  timeout abort flag, valid with rsp_valid.
REQ-012 SHALL provide ports: psel_o, penable_o, pwrite_o (out 1), paddr_o (out 32), pwdata_o (out 8) as APB master request signals.
REQ-013 SHALL provide ports: prdata_i (in 8), pready_i (in 1) as APB slave response.
REQ-014 SHALL provide port: busy  out  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS, DONE.
REQ-016 SHALL assert cmd_ready combinationally only in IDLE.
REQ-017 IDLE: on accept, SHALL latch addr/write/wdata into registers and go to SETUP.
REQ-018 SETUP (exactly one cycle): psel_o=1, penable_o=0; SHALL go to ACCESS.
REQ-019 ACCESS: psel_o=1, penable_o=1; wait counter SHALL clear on entry and increment each cycle in which pready_i=0.
REQ-020 In ACCESS with pready_i=1, SHALL capture prdata_i for reads (0 for writes), set rsp_err=0, and go to DONE.
REQ-021 In ACCESS with pready_i=0 and counter == WAIT_LIMIT-1, SHALL abort: rsp_rdata=0, rsp_err=1, go to DONE.
REQ-022 If pready_i=1 in the same cycle as the limit is reached, pready_i SHALL win (normal completion).
REQ-023 DONE (one cycle): psel_o=0, penable_o=0, rsp_valid=1; SHALL go to IDLE.
REQ-024 paddr_o, pwrite_o, pwdata_o SHALL come from the latched registers and stay stable from SETUP through ACCESS.
REQ-025 pready_i and prdata_i SHALL be ignored outside ACCESS.
REQ-026 cmd_* inputs SHALL be ignored while cmd_ready=0; commands are never queued.
REQ-027 Minimum command-to-command period SHALL be 4 cycles: accept, SETUP, ACCESS, DONE.
REQ-028 rsp_rdata and rsp_err SHALL hold their last value until the next DONE.
REQ-029 The wait counter SHALL be 8 bits and saturate, never wrap.

Reset
REQ-030 On preset_n=0, SHALL enter IDLE and drive psel_o=0, penable_o=0, pwrite_o=0, paddr_o=0, pwdata_o=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, with the wait counter at 0.
REQ-031 Reset mid-transfer SHALL drop psel_o/penable_o immediately and emit no rsp_valid for the aborted command.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (2-bit), APB_ADDR_W=32, APB_DATA_W=8, and the timer register addresses TMR_LOAD=32'hA000 and TMR_CTRL=32'hA001.
REQ-033 The design SHALL be a single module with no sub-modules; the FSM and datapath are small enough to stay flat.

Verification
REQ-034 Write to 32'hA000, data 8'h05, slave pready one cycle into ACCESS: SETUP then 2 ACCESS cycles; rsp_valid pulses with rsp_err=0; bench slave load register reads 8'h05.
REQ-035 Read from 32'hA000, slave returns 8'h03 on pready: rsp_rdata=8'h03 and rsp_err=0; paddr_o is stable through ACCESS.
REQ-036 pready_i held 0 with WAIT_LIMIT=16: exactly 16 ACCESS cycles, then DONE with rsp_err=1 and rsp_rdata=8'h00.
REQ-037 cmd_valid held high for 3 commands with zero-wait slave: accepts 4 cycles apart; cmd_ready=0 in SETUP, ACCESS and DONE.
REQ-038 preset_n asserted during ACCESS: psel_o/penable_o are 0 asynchronously; no rsp_valid; the next command completes normally.
REQ-039 pready_i=1 on the limit cycle: rsp_err=0 and prdata_i is captured.

Source files
------------

// File: rtl/apb_master_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_ctrl_pkg
//  Description : Shared widths, FSM encoding and timer register map for the
//                APB command master.
//  Revision    : 1.0
// ============================================================================
package apb_master_ctrl_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 8;

    localparam logic [APB_ADDR_W-1:0] TMR_LOAD = 32'hA000;
    localparam logic [APB_ADDR_W-1:0] TMR_CTRL = 32'hA001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } apb_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_ctrl
//  Description : Single-transfer APB master with a bounded wait-state timeout.
//  Revision    : 1.0
// ============================================================================
module apb_master_ctrl
    import apb_master_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic                  pclk,
    input  logic                  preset_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [APB_ADDR_W-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [APB_DATA_W-1:0] cmd_wdata,

    output logic                  rsp_valid,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [APB_ADDR_W-1:0] paddr_o,
    output logic [APB_DATA_W-1:0] pwdata_o,
    input  logic [APB_DATA_W-1:0] prdata_i,
    input  logic                  pready_i,

    output logic                  busy
);

    localparam logic [7:0] c_WAIT_LAST = 8'(WAIT_LIMIT - 1);

    apb_state_t r_state;
    logic [7:0] r_wait_cnt;
    logic       w_accept;

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    // The async reset also clears psel/penable, so a reset mid-transfer
    // drops the bus request immediately and suppresses the response pulse.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 8'd0;
            psel_o     <= 1'b0;
            penable_o  <= 1'b0;
            pwrite_o   <= 1'b0;
            paddr_o    <= '0;
            pwdata_o   <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    rsp_valid <= 1'b0;
                    if (w_accept) begin
                        paddr_o  <= cmd_addr;
                        pwrite_o <= cmd_write;
                        pwdata_o <= cmd_wdata;
                        psel_o   <= 1'b1;
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_o  <= 1'b1;
                    r_wait_cnt <= 8'd0;
                    r_state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready_i) begin
                        rsp_rdata <= pwrite_o ? '0 : prdata_i;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        r_state   <= ST_DONE;
                    end else begin
                        if (r_wait_cnt != 8'hFF) begin
                            r_wait_cnt <= r_wait_cnt + 8'd1;
                        end
                        if (r_wait_cnt == c_WAIT_LAST) begin
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            psel_o    <= 1'b0;
                            penable_o <= 1'b0;
                            r_state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    rsp_valid <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_ctrl
//  Description : Self-checking bench for apb_master_ctrl with an APB slave
//                model and a transaction-level reference model.
//  Revision    : 1.0
// ============================================================================
module tb_apb_master_ctrl;
    import apb_master_ctrl_pkg::*;

    localparam int WAIT_LIMIT = 16;

    logic        pclk;
    logic        preset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] paddr_o;
    logic [7:0]  pwdata_o;
    logic [7:0]  prdata_i;
    logic        pready_i;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master_ctrl #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_write (cmd_write),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .pwrite_o  (pwrite_o),
        .paddr_o   (paddr_o),
        .pwdata_o  (pwdata_o),
        .prdata_i  (prdata_i),
        .pready_i  (pready_i),
        .busy      (busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // APB slave: answers after slave_wait stalled ACCESS cycles; outside
    // ACCESS it drives noise that the master must ignore.
    int         slave_wait = 0;
    int         acc_n = 0;
    logic [7:0] slv_mem [256] = '{default: 8'h00};
    logic       in_access;

    assign in_access = psel_o && penable_o;
    assign pready_i  = in_access ? (acc_n >= slave_wait) : 1'b1;
    assign prdata_i  = in_access ? slv_mem[paddr_o[7:0]] : 8'hEE;

    always @(posedge pclk) begin
        acc_n <= (in_access && !pready_i) ? acc_n + 1 : 0;
        if (in_access && pready_i && pwrite_o)
            slv_mem[paddr_o[7:0]] <= pwdata_o;
    end

    // Transaction-level reference: a transfer either completes after
    // wait+1 ACCESS cycles or times out after WAIT_LIMIT of them.
    logic [7:0] model_mem [256] = '{default: 8'h00};

    task automatic model_cmd(input logic [31:0] a, input logic wr, input logic [7:0] d,
                             input int wn, output logic e, output logic [7:0] r,
                             output int acc);
        if (wn >= WAIT_LIMIT) begin
            e = 1'b1; r = 8'h00; acc = WAIT_LIMIT;
        end else begin
            e = 1'b0; acc = wn + 1;
            r = wr ? 8'h00 : model_mem[a[7:0]];
            if (wr) model_mem[a[7:0]] = d;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic wr, input logic [7:0] d,
                           input int wn, input logic e_err, input logic [7:0] e_rd,
                           input int e_acc);
        int   n_set, n_acc, g;
        logic stable, got;
        slave_wait = wn;
        @(negedge pclk);
        g = 0;
        while (!cmd_ready && g < 50) begin @(negedge pclk); g++; end
        cmd_valid = 1'b1; cmd_addr = a; cmd_write = wr; cmd_wdata = d;
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom; cmd_write = 1'($urandom); cmd_wdata = 8'($urandom);
        n_set = 0; n_acc = 0; stable = 1'b1; got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                if (psel_o && !penable_o) n_set++;
                if (psel_o && penable_o)  n_acc++;
                if (psel_o && (paddr_o !== a || pwrite_o !== wr || pwdata_o !== d))
                    stable = 1'b0;
                @(negedge pclk);
            end
        end
        check("rsp_seen", 32'(got), 32'd1);
        check("setup_cycles", n_set, 1);
        check("access_cycles", n_acc, e_acc);
        check("rsp_err", 32'(rsp_err), 32'(e_err));
        check("rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
        check("addr_stable", 32'(stable), 32'd1);
        check("done_psel", 32'({psel_o, penable_o}), 32'd0);
        @(negedge pclk);
        check("rsp_pulse_end", 32'({rsp_valid, cmd_ready}), 32'b01);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [7:0]  wdata;
        int          wn;
        logic        e_err;
        logic [7:0]  e_rd;
        int          e_acc;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic       me;
        logic [7:0] mr;
        int         ma;
        int         stamps [3];
        int         n_acc_cnt, g, n_rsp;
        logic       ready_bad;
        logic [31:0] ra;
        logic        rw;
        logic [7:0]  rd;
        int          rwn;
        int          wsel [9] = '{0, 1, 2, 3, 5, 14, 15, 16, 40};

        tbl[0] = '{TMR_LOAD, 1'b1, 8'h03, 0,  1'b0, 8'h00, 1};
        tbl[1] = '{TMR_LOAD, 1'b0, 8'h00, 1,  1'b0, 8'h03, 2};
        tbl[2] = '{TMR_CTRL, 1'b1, 8'h81, 2,  1'b0, 8'h00, 3};
        tbl[3] = '{TMR_CTRL, 1'b0, 8'h00, 0,  1'b0, 8'h81, 1};
        tbl[4] = '{TMR_CTRL, 1'b0, 8'h00, 16, 1'b1, 8'h00, 16};
        tbl[5] = '{TMR_CTRL, 1'b0, 8'h00, 15, 1'b0, 8'h81, 16};
        tbl[6] = '{TMR_CTRL, 1'b1, 8'hC3, 16, 1'b1, 8'h00, 16};
        tbl[7] = '{TMR_CTRL, 1'b0, 8'h00, 0,  1'b0, 8'h81, 1};
        tbl[8] = '{TMR_LOAD, 1'b1, 8'h05, 1,  1'b0, 8'h00, 2};

        preset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
        repeat (3) @(negedge pclk);
        check("rst_bus", 32'({psel_o, penable_o, pwrite_o}), 32'd0);
        check("rst_paddr", paddr_o, 32'd0);
        check("rst_pwdata", 32'(pwdata_o), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
        check("rst_busy_ready", 32'({busy, cmd_ready}), 32'b01);
        preset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            model_cmd(tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].wn, me, mr, ma);
            run_cmd(tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].wn,
                    tbl[i].e_err, tbl[i].e_rd, tbl[i].e_acc);
        end
        check("slave_load_reg", 32'(slv_mem[TMR_LOAD[7:0]]), 32'h05);

        model_cmd(TMR_LOAD, 1'b0, 8'h00, 0, me, mr, ma);
        run_cmd(TMR_LOAD, 1'b0, 8'h00, 0, 1'b0, 8'h05, 1);
        repeat (3) @(negedge pclk);
        check("rsp_hold", 32'({rsp_err, rsp_rdata}), 32'h005);

        // Back-to-back commands with cmd_valid held high.
        slave_wait = 0;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_addr = TMR_CTRL; cmd_write = 1'b1; cmd_wdata = 8'h11;
        n_acc_cnt = 0; ready_bad = 1'b0;
        for (int c = 0; c < 40 && n_acc_cnt < 3; c++) begin
            if (cmd_ready === busy) ready_bad = 1'b1;
            if (cmd_ready) begin stamps[n_acc_cnt] = c; n_acc_cnt++; end
            @(negedge pclk);
        end
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) model_cmd(TMR_CTRL, 1'b1, 8'h11, 0, me, mr, ma);
        check("b2b_count", n_acc_cnt, 3);
        check("b2b_gap1", stamps[1] - stamps[0], 4);
        check("b2b_gap2", stamps[2] - stamps[1], 4);
        check("b2b_ready_busy", 32'(ready_bad), 32'd0);
        repeat (5) @(negedge pclk);
        check("b2b_slave", 32'(slv_mem[TMR_CTRL[7:0]]), 32'h11);

        // Reset asserted in the middle of ACCESS.
        slave_wait = 1000;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_addr = TMR_LOAD; cmd_write = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        g = 0;
        while (!(psel_o && penable_o) && g < 20) begin @(negedge pclk); g++; end
        check("rst_mid_reached", 32'(psel_o && penable_o), 32'd1);
        @(negedge pclk);
        #2 preset_n = 1'b0;
        #1;
        check("rst_mid_drop", 32'({psel_o, penable_o, busy}), 32'd0);
        @(negedge pclk);
        @(negedge pclk);
        preset_n = 1'b1;
        n_rsp = 0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid) n_rsp++;
            @(negedge pclk);
        end
        check("rst_mid_no_rsp", n_rsp, 0);
        model_cmd(TMR_LOAD, 1'b0, 8'h00, 2, me, mr, ma);
        run_cmd(TMR_LOAD, 1'b0, 8'h00, 2, me, mr, ma);

        // Randomized commands against the reference model.
        for (int i = 0; i < 30; i++) begin
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (TMR_LOAD + 32'($urandom_range(0, 1)));
            rw  = 1'($urandom);
            rd  = 8'($urandom);
            rwn = wsel[$urandom_range(0, 8)];
            model_cmd(ra, rw, rd, rwn, me, mr, ma);
            run_cmd(ra, rw, rd, rwn, me, mr, ma);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
